// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared pointer types and Gray-code helpers for the async FIFO write/read controllers.
package fifo_wr_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned MAX_PTR_W  = 32;

  typedef logic [ADDR_W_DEF:0] ptr_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

  // Operates on zero-extended pointers; upper zero bits do not disturb the result.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = int'(MAX_PTR_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary + Gray pointer register pair; advances by one on i_inc.
module fifo_gray_ptr
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int unsigned PTR_W = ADDR_W_DEF + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_bin,
  output logic [PTR_W-1:0] o_bin_nxt,
  output logic [PTR_W-1:0] o_gray,
  output logic [PTR_W-1:0] o_gray_nxt
);

  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] r_gray;
  logic [PTR_W-1:0] w_bin_nxt;
  logic [PTR_W-1:0] w_gray_nxt;

  always_comb begin
    w_bin_nxt  = i_inc ? PTR_W'(r_bin + PTR_W'(1)) : r_bin;
    w_gray_nxt = PTR_W'(bin2gray(MAX_PTR_W'(w_bin_nxt)));
  end

  // Gray value held in its own flop so the cross-domain output is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
    end
  end

  assign o_bin      = r_bin;
  assign o_bin_nxt  = w_bin_nxt;
  assign o_gray     = r_gray;
  assign o_gray_nxt = w_gray_nxt;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer and flag controller of the async FIFO.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_ptr_gray_sync,
  input  logic              clr_overflow,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              wr_full,
  output logic              wr_almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int unsigned PTR_W    = ADDR_W + 1;
  localparam int unsigned DEPTH    = depth_of(ADDR_W);
  localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

  logic             w_push;
  logic [PTR_W-1:0] w_bin;
  logic [PTR_W-1:0] w_bin_nxt;
  logic [PTR_W-1:0] w_gray;
  logic [PTR_W-1:0] w_gray_nxt;
  logic [PTR_W-1:0] w_rq_bin;
  logic [PTR_W-1:0] w_full_gray;
  logic [PTR_W-1:0] w_level_nxt;
  logic             w_full_nxt;
  logic             w_af_nxt;
  logic             w_ovf_nxt;
  logic             w_unused_bin_msb;

  logic             r_full;
  logic             r_almost_full;
  logic [PTR_W-1:0] r_level;
  logic             r_overflow;

  assign w_push           = wr_en & ~r_full;
  assign w_unused_bin_msb = w_bin[ADDR_W];

  fifo_gray_ptr #(
    .PTR_W (PTR_W)
  ) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_push),
    .o_bin      (w_bin),
    .o_bin_nxt  (w_bin_nxt),
    .o_gray     (w_gray),
    .o_gray_nxt (w_gray_nxt)
  );

  // Full when the next write pointer sits exactly one lap ahead of the read pointer.
  always_comb begin
    w_rq_bin    = PTR_W'(gray2bin(MAX_PTR_W'(rd_ptr_gray_sync)));
    w_full_gray = {~rd_ptr_gray_sync[ADDR_W:ADDR_W-1], rd_ptr_gray_sync[ADDR_W-2:0]};
    w_full_nxt  = (w_gray_nxt == w_full_gray);
    w_level_nxt = PTR_W'(w_bin_nxt - w_rq_bin);
    w_af_nxt    = (w_level_nxt >= PTR_W'(AF_LEVEL));
    w_ovf_nxt   = (wr_en & r_full) | (r_overflow & ~clr_overflow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_level       <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_full        <= w_full_nxt;
      r_almost_full <= w_af_nxt;
      r_level       <= w_level_nxt;
      r_overflow    <= w_ovf_nxt;
    end
  end

  assign ram_we         = w_push;
  assign ram_waddr      = w_bin[ADDR_W-1:0];
  assign wr_ptr_gray    = w_gray;
  assign wr_full        = r_full;
  assign wr_almost_full = r_almost_full;
  assign wr_level       = r_level;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl (ADDR_W=3, AF_MARGIN=2 and 1).
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] rq;
  logic       clr_overflow;

  logic       ram_we,  ram_we1;
  logic [2:0] ram_waddr, ram_waddr1;
  logic [3:0] wr_ptr_gray, wr_ptr_gray1;
  logic       wr_full, wr_full1;
  logic       wr_af, wr_af1;
  logic [3:0] wr_level, wr_level1;
  logic       overflow, overflow1;

  int errors = 0;
  int checks = 0;

  fifo_wr_ctrl #(.ADDR_W(3), .AF_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_ptr_gray_sync(rq),
    .clr_overflow(clr_overflow), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .wr_ptr_gray(wr_ptr_gray), .wr_full(wr_full), .wr_almost_full(wr_af),
    .wr_level(wr_level), .overflow(overflow)
  );

  fifo_wr_ctrl #(.ADDR_W(3), .AF_MARGIN(1)) dut_af1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_ptr_gray_sync(rq),
    .clr_overflow(clr_overflow), .ram_we(ram_we1), .ram_waddr(ram_waddr1),
    .wr_ptr_gray(wr_ptr_gray1), .wr_full(wr_full1), .wr_almost_full(wr_af1),
    .wr_level(wr_level1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] g4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; clr_overflow = 1'b0; rq = 4'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    wr_en = 1'b1;
    repeat (3) step();
    wr_en = 1'b0;
    checks++;
    if (wr_level !== 4'd3) begin
      errors++; $display("FAIL reset_pre_level: got %0d want 3", wr_level);
    end
    // assert reset mid-cycle, away from any edge
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ram_we, ram_waddr, wr_ptr_gray, wr_full, wr_af, wr_level, overflow} !== 15'd0) begin
      errors++;
      $display("FAIL reset_async: we=%b waddr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b want all 0",
               ram_we, ram_waddr, wr_ptr_gray, wr_full, wr_af, wr_level, overflow);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    rq = 4'd0; wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (ram_we !== 1'b1 || ram_waddr !== 3'(i)) begin
        errors++; $display("FAIL fill_addr[%0d]: we=%b waddr=%0d want we=1 waddr=%0d", i, ram_we, ram_waddr, i);
      end
      step();
    end
    checks++;
    if (wr_full !== 1'b1 || wr_ptr_gray !== 4'b1100 || wr_level !== 4'd8 || wr_af !== 1'b1) begin
      errors++; $display("FAIL fill_full: full=%b gray=%b lvl=%0d af=%b want 1 1100 8 1", wr_full, wr_ptr_gray, wr_level, wr_af);
    end
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++; $display("FAIL fill_9th_we: got %b want 0", ram_we);
    end
    step();
    wr_en = 1'b0;
    checks++;
    if (wr_ptr_gray !== 4'b1100 || ram_waddr !== 3'd0 || overflow !== 1'b1 || wr_full !== 1'b1) begin
      errors++; $display("FAIL fill_overflow: gray=%b waddr=%0d ovf=%b full=%b want 1100 0 1 1", wr_ptr_gray, ram_waddr, overflow, wr_full);
    end
  endtask

  task automatic test_overflow_clear();
    wr_en = 1'b1; clr_overflow = 1'b1;
    step();
    checks++;
    if (overflow !== 1'b1 || wr_ptr_gray !== 4'b1100) begin
      errors++; $display("FAIL ovf_set_wins: ovf=%b gray=%b want 1 1100", overflow, wr_ptr_gray);
    end
    wr_en = 1'b0;
    step();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    step();
    checks++;
    if (overflow !== 1'b0 || wr_full !== 1'b1) begin
      errors++; $display("FAIL ovf_stays_clear: ovf=%b full=%b want 0 1", overflow, wr_full);
    end
  endtask

  task automatic test_drain();
    rq = 4'b0001;
    step();
    checks++;
    if (wr_full !== 1'b0 || wr_level !== 4'd7) begin
      errors++; $display("FAIL drain_one: full=%b lvl=%0d want 0 7", wr_full, wr_level);
    end
    rq = 4'b1100;
    step();
    checks++;
    if (wr_level !== 4'd0 || wr_af !== 1'b0 || wr_full !== 1'b0) begin
      errors++; $display("FAIL drain_all: lvl=%0d af=%b full=%b want 0 0 0", wr_level, wr_af, wr_full);
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    rq = 4'd0; wr_en = 1'b1;
    repeat (5) step();
    checks++;
    if (wr_af !== 1'b0 || wr_af1 !== 1'b0 || wr_level !== 4'd5) begin
      errors++; $display("FAIL af_at5: af=%b af1=%b lvl=%0d want 0 0 5", wr_af, wr_af1, wr_level);
    end
    step();
    checks++;
    if (wr_af !== 1'b1 || wr_af1 !== 1'b0 || wr_level !== 4'd6) begin
      errors++; $display("FAIL af_at6: af=%b af1=%b lvl=%0d want 1 0 6", wr_af, wr_af1, wr_level);
    end
    step();
    wr_en = 1'b0;
    checks++;
    if (wr_af !== 1'b1 || wr_af1 !== 1'b1 || wr_level1 !== 4'd7 || wr_full !== 1'b0) begin
      errors++; $display("FAIL af_at7: af=%b af1=%b lvl1=%0d full=%b want 1 1 7 0", wr_af, wr_af1, wr_level1, wr_full);
    end
  endtask

  task automatic test_wrap();
    int wp;
    int rd;
    logic [3:0] prev;
    logic seen_wrap;
    do_reset();
    wp = 0; prev = 4'd0; seen_wrap = 1'b0;
    wr_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rd = (wp >= 2) ? wp - 2 : 0;
      rq = g4(rd);
      step();
      wp++;
      checks++;
      if (wr_ptr_gray !== g4(wp) || wr_full !== 1'b0 || wr_level !== 4'((wp - rd) & 15)) begin
        errors++; $display("FAIL wrap[%0d]: gray=%b full=%b lvl=%0d want %b 0 %0d", k, wr_ptr_gray, wr_full, wr_level, g4(wp), (wp - rd) & 15);
      end
      checks++;
      if ($countones(wr_ptr_gray ^ prev) != 1) begin
        errors++; $display("FAIL wrap_gray_step[%0d]: %b -> %b not a 1-bit change", k, prev, wr_ptr_gray);
      end
      if ((wp % 16) == 0 && prev == 4'b1000 && wr_ptr_gray == 4'b0000) seen_wrap = 1'b1;
      prev = wr_ptr_gray;
    end
    wr_en = 1'b0;
    checks++;
    if (seen_wrap !== 1'b1) begin
      errors++; $display("FAIL wrap_seen: got %b want 1", seen_wrap);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rq = 4'd0; clr_overflow = 1'b0;
    test_reset();
    test_fill();
    test_overflow_clear();
    test_drain();
    test_almost_full();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
